// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory bus between the IF fetch port and the MEM data port.
// Latency: request in cycle 0 -> bus_cyc in cycle 1 -> bus_ack in cycle k -> port ack/rdata in cycle k+1.
// Backpressure: ports hold req until ack; stallreq freezes the pipeline while any port waits.
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to force completion (ack+err) after TIMEOUT wait cycles.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    // fetch port (IF stage)
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    output logic                if_err,
    // data port (MEM stage)
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_sel,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_ack,
    output logic                mem_err,
    // external memory bus
    output logic                bus_cyc,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_sel,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack,
    // status to the pipeline controller
    output logic                owner,
    output logic                stallreq
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    state_t              state_q;
    logic                bus_cyc_q;
    logic                bus_we_q;
    logic [SEL_W-1:0]    bus_sel_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic                owner_q;
    logic                if_ack_q;
    logic                if_err_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic                mem_ack_q;
    logic                mem_err_q;
    logic [DATA_W-1:0]   mem_rdata_q;

    logic busy;
    logic arb_ok;
    logic timeout_hit;

    assign busy = (state_q != IDLE);

    // The IDLE cycle that carries an ack is not arbitrated: the requester
    // still holds req in that cycle and would otherwise be granted twice.
    assign arb_ok = (state_q == IDLE) && !if_ack_q && !mem_ack_q;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    assign wait_cnt_d  = wait_cnt_q + 1'b1;
    // bus_ack in the same cycle as the limit wins, so it masks the timeout.
    assign timeout_hit = busy && !bus_ack && (wait_cnt_d == CNT_W'(TIMEOUT));

    // Wait counter: held at zero while idle (clears on grant), counts BUSY cycles without bus_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (!busy) begin
            wait_cnt_q <= '0;
        end else if (!bus_ack) begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic timeout_unused;

    // Without the timeout a transaction waits for bus_ack indefinitely.
    assign timeout_hit    = 1'b0;
    assign timeout_unused = (TIMEOUT != 0);
`endif

    // Arbiter FSM with registered bus outputs, acks, errors and read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_cyc_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            owner_q     <= 1'b0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_ack_q   <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            // Acks and errors are single-cycle pulses.
            if_ack_q  <= 1'b0;
            if_err_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            mem_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (arb_ok) begin
                        // Data port has fixed priority: it carries the older instruction.
                        if (mem_req) begin
                            state_q     <= MEM_BUSY;
                            bus_cyc_q   <= 1'b1;
                            bus_we_q    <= mem_we;
                            bus_sel_q   <= mem_sel;
                            bus_addr_q  <= mem_addr;
                            bus_wdata_q <= mem_wdata;
                            owner_q     <= 1'b1;
                        end else if (if_req) begin
                            state_q     <= IF_BUSY;
                            bus_cyc_q   <= 1'b1;
                            bus_we_q    <= 1'b0;
                            bus_sel_q   <= '1;
                            bus_addr_q  <= if_addr;
                            bus_wdata_q <= '0;
                            owner_q     <= 1'b0;
                        end
                    end
                end

                IF_BUSY: begin
                    // Bus fields stay frozen until completion; no preemption.
                    if (bus_ack || timeout_hit) begin
                        state_q    <= IDLE;
                        bus_cyc_q  <= 1'b0;
                        bus_we_q   <= 1'b0;
                        if_ack_q   <= 1'b1;
                        if_err_q   <= timeout_hit;
                        if_rdata_q <= bus_ack ? bus_rdata : '0;
                    end
                end

                MEM_BUSY: begin
                    if (bus_ack || timeout_hit) begin
                        state_q     <= IDLE;
                        bus_cyc_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        mem_ack_q   <= 1'b1;
                        mem_err_q   <= timeout_hit;
                        // Writes and timed-out reads return zero data.
                        mem_rdata_q <= (bus_ack && !bus_we_q) ? bus_rdata : '0;
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    bus_cyc_q <= 1'b0;
                    bus_we_q  <= 1'b0;
                end
            endcase
        end
    end

    // Stall while a port has an outstanding request; forced low during reset.
    assign stallreq = !rst && ((if_req && !if_ack_q) || (mem_req && !mem_ack_q));

    assign bus_cyc   = bus_cyc_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign owner     = owner_q;
    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign mem_ack   = mem_ack_q;
    assign mem_err   = mem_err_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Cycle c of a scenario is the clock period in which its stimulus for c is applied.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;
    logic        bus_cyc;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        owner;
    logic        stallreq;

    int total;
    int bad;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_err    (if_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_err   (mem_err),
        .bus_cyc   (bus_cyc),
        .bus_we    (bus_we),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .owner     (owner),
        .stallreq  (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_req = 1'b1;
        @(negedge clk);
        total++;
        if ({bus_cyc, bus_we, bus_sel, if_ack, mem_ack, if_err, mem_err, owner, stallreq} !== 12'h000) begin
            bad++;
            $display("FAIL reset_ctrl got %b want 0", {bus_cyc, bus_we, bus_sel, if_ack, mem_ack, if_err, mem_err, owner, stallreq});
        end
        total++;
        if ({if_rdata, mem_rdata, bus_addr, bus_wdata} !== 128'h0) begin
            bad++;
            $display("FAIL reset_data got %h %h %h %h want 0", if_rdata, mem_rdata, bus_addr, bus_wdata);
        end
        mem_req = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_fetch_only;
        logic [4:0] exp_cyc = 5'b00110;
        logic [4:0] exp_ack = 5'b01000;
        logic [4:0] exp_st  = 5'b00111;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h0000_0004;
            end
            if (c == 4) if_req = 1'b0;
            bus_ack   = (c == 2);
            bus_rdata = (c == 2) ? 32'h3401_1100 : 32'h0;
            @(negedge clk);
            total++;
            if ({bus_cyc, if_ack, stallreq} !== {exp_cyc[c], exp_ack[c], exp_st[c]}) begin
                bad++;
                $display("FAIL fetch c%0d cyc/ack/stall got %b want %b", c, {bus_cyc, if_ack, stallreq}, {exp_cyc[c], exp_ack[c], exp_st[c]});
            end
            if (c == 1) begin
                total++;
                if ({bus_we, bus_sel, bus_addr, owner} !== {1'b0, 4'hF, 32'h0000_0004, 1'b0}) begin
                    bad++;
                    $display("FAIL fetch_bus we=%b sel=%h addr=%h owner=%b want 0 f 00000004 0", bus_we, bus_sel, bus_addr, owner);
                end
            end
            if (c == 3) begin
                total++;
                if ({if_rdata, if_err, mem_ack} !== {32'h3401_1100, 1'b0, 1'b0}) begin
                    bad++;
                    $display("FAIL fetch_rdata got %h err=%b mem_ack=%b want 34011100 0 0", if_rdata, if_err, mem_ack);
                end
            end
            if (c == 4) begin
                total++;
                if (if_rdata !== 32'h3401_1100) begin
                    bad++;
                    $display("FAIL fetch_rdata_hold got %h want 34011100", if_rdata);
                end
            end
            next_cycle();
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_data_write;
        logic [6:0] exp_cyc = 7'b0011110;
        logic [6:0] exp_ack = 7'b0100000;
        logic [6:0] exp_st  = 7'b0011111;
        for (int c = 0; c < 7; c++) begin
            if (c == 0) begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_sel   = 4'h3;
                mem_addr  = 32'h0000_0100;
                mem_wdata = 32'hDEAD_BEEF;
            end
            if (c == 6) mem_req = 1'b0;
            bus_ack   = (c == 4);
            bus_rdata = (c == 4) ? 32'h5555_5555 : 32'h0;
            @(negedge clk);
            total++;
            if ({bus_cyc, mem_ack, stallreq} !== {exp_cyc[c], exp_ack[c], exp_st[c]}) begin
                bad++;
                $display("FAIL write c%0d cyc/ack/stall got %b want %b", c, {bus_cyc, mem_ack, stallreq}, {exp_cyc[c], exp_ack[c], exp_st[c]});
            end
            if (c == 1 || c == 4) begin
                total++;
                if ({bus_we, bus_sel, bus_addr, bus_wdata, owner} !== {1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1}) begin
                    bad++;
                    $display("FAIL write_bus c%0d we=%b sel=%h addr=%h wdata=%h owner=%b", c, bus_we, bus_sel, bus_addr, bus_wdata, owner);
                end
            end
            if (c == 5) begin
                total++;
                if ({mem_rdata, mem_err, if_ack, bus_we} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
                    bad++;
                    $display("FAIL write_done rdata=%h err=%b if_ack=%b bus_we=%b want 0 0 0 0", mem_rdata, mem_err, if_ack, bus_we);
                end
            end
            next_cycle();
        end
        bus_ack = 1'b0;
        mem_we  = 1'b0;
    endtask

    task automatic test_contention;
        // {bus_cyc, owner, mem_ack, if_ack, stallreq}
        logic [4:0] ev [9];
        ev = '{5'b01001, 5'b11001, 5'b11001, 5'b01101, 5'b01001,
               5'b10001, 5'b10001, 5'b00010, 5'b00000};
        for (int c = 0; c < 9; c++) begin
            if (c == 0) begin
                mem_req  = 1'b1;
                mem_we   = 1'b0;
                mem_sel  = 4'hF;
                mem_addr = 32'h0000_0200;
                if_req   = 1'b1;
                if_addr  = 32'h0000_0008;
            end
            if (c == 4) mem_req = 1'b0;
            if (c == 8) if_req = 1'b0;
            bus_ack   = (c == 2) || (c == 6);
            bus_rdata = (c == 2) ? 32'hA5A5_0001 : ((c == 6) ? 32'h0BAD_F00D : 32'h0);
            @(negedge clk);
            total++;
            if ({bus_cyc, owner, mem_ack, if_ack, stallreq} !== ev[c]) begin
                bad++;
                $display("FAIL contend c%0d cyc/own/mack/iack/stall got %b want %b", c, {bus_cyc, owner, mem_ack, if_ack, stallreq}, ev[c]);
            end
            if (c == 1) begin
                total++;
                if ({bus_addr, bus_we} !== {32'h0000_0200, 1'b0}) begin
                    bad++;
                    $display("FAIL contend_mem_bus addr=%h we=%b want 00000200 0", bus_addr, bus_we);
                end
            end
            if (c == 3) begin
                total++;
                if (mem_rdata !== 32'hA5A5_0001) begin
                    bad++;
                    $display("FAIL contend_mem_rdata got %h want a5a50001", mem_rdata);
                end
            end
            if (c == 5) begin
                total++;
                if ({bus_addr, bus_sel, bus_we} !== {32'h0000_0008, 4'hF, 1'b0}) begin
                    bad++;
                    $display("FAIL contend_if_bus addr=%h sel=%h we=%b want 00000008 f 0", bus_addr, bus_sel, bus_we);
                end
            end
            if (c == 7) begin
                total++;
                if (if_rdata !== 32'h0BAD_F00D) begin
                    bad++;
                    $display("FAIL contend_if_rdata got %h want 0badf00d", if_rdata);
                end
            end
            next_cycle();
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_abandon;
        // {bus_cyc, owner, mem_ack, if_ack, stallreq}
        logic [4:0] ev [10];
        ev = '{5'b00001, 5'b11001, 5'b11000, 5'b11000, 5'b01100,
               5'b01001, 5'b10001, 5'b10001, 5'b00010, 5'b00000};
        for (int c = 0; c < 10; c++) begin
            if (c == 0) begin
                mem_req  = 1'b1;
                mem_we   = 1'b0;
                mem_addr = 32'h0000_0300;
            end
            if (c == 2) mem_req = 1'b0;
            if (c == 5) begin
                if_req  = 1'b1;
                if_addr = 32'h0000_000C;
            end
            if (c == 9) if_req = 1'b0;
            bus_ack   = (c == 3) || (c == 7);
            bus_rdata = (c == 3) ? 32'h1111_2222 : ((c == 7) ? 32'h0000_0077 : 32'h0);
            @(negedge clk);
            total++;
            if ({bus_cyc, owner, mem_ack, if_ack, stallreq} !== ev[c]) begin
                bad++;
                $display("FAIL abandon c%0d cyc/own/mack/iack/stall got %b want %b", c, {bus_cyc, owner, mem_ack, if_ack, stallreq}, ev[c]);
            end
            if (c == 4) begin
                total++;
                if (mem_rdata !== 32'h1111_2222) begin
                    bad++;
                    $display("FAIL abandon_rdata got %h want 11112222", mem_rdata);
                end
            end
            if (c == 6) begin
                total++;
                if (bus_addr !== 32'h0000_000C) begin
                    bad++;
                    $display("FAIL abandon_next_addr got %h want 0000000c", bus_addr);
                end
            end
            if (c == 8) begin
                total++;
                if (if_rdata !== 32'h0000_0077) begin
                    bad++;
                    $display("FAIL abandon_next_rdata got %h want 00000077", if_rdata);
                end
            end
            next_cycle();
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_idle_ack;
        for (int c = 0; c < 3; c++) begin
            bus_ack   = 1'b1;
            bus_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            total++;
            if ({bus_cyc, if_ack, mem_ack, stallreq, if_rdata, mem_rdata} !== {4'b0000, 32'h0000_0077, 32'h1111_2222}) begin
                bad++;
                $display("FAIL idle_ack c%0d cyc/iack/mack/stall=%b if_rdata=%h mem_rdata=%h", c, {bus_cyc, if_ack, mem_ack, stallreq}, if_rdata, mem_rdata);
            end
            next_cycle();
        end
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
    endtask

    task automatic test_async_reset;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_sel   = 4'hF;
        mem_addr  = 32'h0000_0400;
        mem_wdata = 32'h0000_1234;
        next_cycle();
        @(negedge clk);
        total++;
        if ({bus_cyc, owner, stallreq} !== 3'b111) begin
            bad++;
            $display("FAIL areset_pre cyc/own/stall got %b want 111", {bus_cyc, owner, stallreq});
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus_cyc, bus_we, if_ack, mem_ack, owner, stallreq, if_rdata, mem_rdata} !== {6'b000000, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL areset_now cyc/we/iack/mack/own/stall=%b if_rdata=%h mem_rdata=%h", {bus_cyc, bus_we, if_ack, mem_ack, owner, stallreq}, if_rdata, mem_rdata);
        end
        next_cycle();
        rst     = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bus_ack = (c == 0);
            @(negedge clk);
            total++;
            if ({bus_cyc, mem_ack, if_ack, stallreq} !== 4'b0000) begin
                bad++;
                $display("FAIL areset_after c%0d cyc/mack/iack/stall got %b want 0000", c, {bus_cyc, mem_ack, if_ack, stallreq});
            end
            next_cycle();
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h0000_0010;
            end
            if (c == 4) if_req = 1'b0;
            bus_ack   = (c == 2);
            bus_rdata = (c == 2) ? 32'hCAFE_0001 : 32'h0;
            @(negedge clk);
            if (c == 1) begin
                total++;
                if ({bus_cyc, bus_addr, owner} !== {1'b1, 32'h0000_0010, 1'b0}) begin
                    bad++;
                    $display("FAIL areset_fetch_bus cyc=%b addr=%h own=%b want 1 00000010 0", bus_cyc, bus_addr, owner);
                end
            end
            if (c == 3) begin
                total++;
                if ({if_ack, if_rdata, bus_cyc} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin
                    bad++;
                    $display("FAIL areset_fetch_done ack=%b rdata=%h cyc=%b want 1 cafe0001 0", if_ack, if_rdata, bus_cyc);
                end
            end
            next_cycle();
        end
        bus_ack = 1'b0;
    endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
    task automatic test_timeout;
        // {bus_cyc, if_ack, if_err}; run 1 acks on the timeout cycle
        logic [2:0] ev0 [7];
        logic [2:0] ev1 [7];
        ev0 = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b011, 3'b000};
        ev1 = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b000};
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 7; c++) begin
                if (c == 0) begin
                    if_req  = 1'b1;
                    if_addr = 32'h0000_0020;
                end
                if (c == 6) if_req = 1'b0;
                bus_ack   = (r == 1) && (c == 4);
                bus_rdata = bus_ack ? 32'h0000_0099 : 32'h0;
                @(negedge clk);
                total++;
                if ({bus_cyc, if_ack, if_err} !== ((r == 0) ? ev0[c] : ev1[c])) begin
                    bad++;
                    $display("FAIL timeout r%0d c%0d cyc/ack/err got %b want %b", r, c, {bus_cyc, if_ack, if_err}, (r == 0) ? ev0[c] : ev1[c]);
                end
                if (c == 5) begin
                    total++;
                    if (if_rdata !== ((r == 0) ? 32'h0 : 32'h0000_0099)) begin
                        bad++;
                        $display("FAIL timeout_rdata r%0d got %h", r, if_rdata);
                    end
                end
                next_cycle();
            end
        end
        bus_ack = 1'b0;
    endtask
`endif

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        bus_rdata = 32'h0;
        bus_ack   = 1'b0;

        test_reset();
        test_fetch_only();
        test_data_write();
        test_contention();
        test_abandon();
        test_idle_ack();
        test_async_reset();
`ifdef MEM_ARBITER_TIMEOUT_EN
        test_timeout();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
